// File: rtl/bit_serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SUB_SIGNED_OVF_EN.
module bit_serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic             br;

    logic a_i;
    logic b_i;
    logic d_i;
    logic br_nxt;

    // One full-subtractor cell applied to the current LSBs of the operand shifters
    assign a_i    = a_sh[0];
    assign b_i    = b_sh[0];
    assign d_i    = a_i ^ b_i ^ br;
    assign br_nxt = (~a_i & b_i) | (~(a_i ^ b_i) & br);

    assign in_ready = (state == IDLE) && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            cnt       <= '0;
            br        <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            out_valid <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= {d_i, res[WIDTH-1:1]};
                    br   <= br_nxt;
                    cnt  <= cnt + CNT_W'(1);
                    // Last bit: a_i/b_i are now the operand MSBs and d_i the result MSB
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        diff      <= {d_i, res[WIDTH-1:1]};
                        borrow    <= br_nxt;
`ifdef SUB_SIGNED_OVF_EN
                        ovf       <= (a_i ^ b_i) & (a_i ^ d_i);
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench for bit_serial_subtractor: arithmetic/timing model plus directed literal checks.
// Define SUB_SIGNED_OVF_EN for both files to exercise the ovf output.
module tb_bit_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SUB_SIGNED_OVF_EN
    logic         ovf;
`endif

    bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
`ifdef SUB_SIGNED_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: accept time + W cycles gives completion; values from plain arithmetic
    int           cyc      = 0;
    int           m_acc    = 0;
    bit           m_busy   = 1'b0;
    bit           m_valid  = 1'b0;
    logic [W-1:0] m_diff   = '0;
    logic         m_borrow = 1'b0;
    logic         m_ovf    = 1'b0;
    logic [W-1:0] p_diff   = '0;
    logic         p_borrow = 1'b0;
    logic         p_ovf    = 1'b0;

    always @(posedge clk) begin
        int sa;
        int sb;
        int sd;
        cyc++;
        if (!rst_n) begin
            m_busy   = 1'b0;
            m_valid  = 1'b0;
            m_diff   = '0;
            m_borrow = 1'b0;
            m_ovf    = 1'b0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
            end
        end else if (m_busy) begin
            if (cyc == m_acc + int'(W)) begin
                m_valid  = 1'b1;
                m_diff   = p_diff;
                m_borrow = p_borrow;
                m_ovf    = p_ovf;
            end
        end else if (in_valid) begin
            m_busy   = 1'b1;
            m_acc    = cyc;
            p_diff   = W'(a - b);
            p_borrow = (a < b);
            sa       = int'($signed(a));
            sb       = int'($signed(b));
            sd       = sa - sb;
            p_ovf    = (sd < -(2 ** (W - 1))) || (sd > (2 ** (W - 1)) - 1);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mdl_out_valid", 32'(out_valid), 32'(m_valid));
            chk("mdl_in_ready", 32'(in_ready), 32'(!m_busy && rst_n));
            chk("mdl_diff", 32'(diff), 32'(m_diff));
            chk("mdl_borrow", 32'(borrow), 32'(m_borrow));
`ifdef SUB_SIGNED_OVF_EN
            chk("mdl_ovf", 32'(ovf), 32'(m_ovf));
`endif
        end
    end

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk({nm, "_ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    // Single transaction with out_ready high; checks latency and literal result
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic [W-1:0] ed, input logic eb, input string nm);
        int lat = 0;
        wait_ready(nm);
        a         = xa;
        b         = xb;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(W));
        chk({nm, "_diff"}, 32'(diff), 32'(ed));
        chk({nm, "_borrow"}, 32'(borrow), 32'(eb));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int last;
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef SUB_SIGNED_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk_en = 1'b1;

        run_op(8'd6, 8'd2, 8'd4, 1'b0, "basic");
        run_op(8'd2, 8'd4, 8'hFE, 1'b1, "wrap");
        run_op(8'd0, 8'hFF, 8'h01, 1'b1, "zero_minus_max");
        run_op(8'h5A, 8'h5A, 8'h00, 1'b0, "equal");
        run_op(8'hFF, 8'h00, 8'hFF, 1'b0, "max_minus_zero");

        // Backpressure: result held, new operands ignored
        wait_ready("bp");
        a         = 8'h30;
        b         = 8'h10;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = W'(8'hA0 + i);
            b        = 8'h01;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_diff", 32'(diff), 32'h20);
            chk("bp_borrow", 32'(borrow), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_released_valid", 32'(out_valid), 32'd0);
        chk("bp_held_diff", 32'(diff), 32'h20);

        // Back-to-back: in_valid and out_ready held high
        in_valid = 1'b1;
        last     = -1;
        for (int k = 0; k < 256; k++) begin
            a = W'($urandom);
            b = W'($urandom);
            wait_ready("b2b");
            @(posedge clk);
            #1;
            if (last >= 0) chk("b2b_interval", 32'(cyc - last), 32'(W + 2));
            last = cyc;
        end
        in_valid = 1'b0;
        wait_ready("b2b_drain");

        // Reset in the middle of RUN
        a        = 8'h9C;
        b        = 8'h31;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_diff", 32'(diff), 32'd0);
        chk("mrst_borrow", 32'(borrow), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mrst_rel_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("mrst_no_result", 32'(out_valid), 32'd0);
        end

`ifdef SUB_SIGNED_OVF_EN
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, "ovf_set");
        chk("ovf_set_flag", 32'(ovf), 32'd1);
        run_op(8'h05, 8'h03, 8'h02, 1'b0, "ovf_clr");
        chk("ovf_clr_flag", 32'(ovf), 32'd0);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bit_serial_subtractor.md
# bit_serial_subtractor

Sequential unsigned subtractor that computes `diff = a - b` one bit per clock, LSB first, using a valid/ready handshake on both sides. It is the inverse companion to the team's combinational adder functions: a sum and one addend go in, and the other addend plus a borrow flag come out. It is intended for area-constrained datapaths where a WIDTH-bit ripple subtractor per lane is too costly.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is 2–32.
- `clk`  input  1  rising-edge clock for all state.
- `rst_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid`  input  1  operands `a` and `b` are valid.
- `in_ready`  output  1  block is able to accept operands.
- `a`  input  WIDTH  minuend.
- `b`  input  WIDTH  subtrahend.
- `out_valid`  output  1  `diff`/`borrow` hold a completed result.
- `out_ready`  input  1  downstream consumer accepts the result.
- `diff`  output  WIDTH  `a - b` modulo 2^WIDTH.
- `borrow`  output  1  is 1 when `a < b` (unsigned).
- `ovf`  output  1  signed overflow flag; this port exists only when `SUB_SIGNED_OVF_EN` is defined.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`, latch `a` and `b` into shift registers.
  - Clear the internal borrow `br` and the bit counter.
  - Go to RUN.
- **RUN**
  - Each cycle processes bit i = cnt.
  - Result bit: `d_i = a_i ^ b_i ^ br`.
  - Next borrow: `br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)`.
  - `d_i` shifts into the result register from the MSB side; both operand registers shift right by one.
  - When cnt == WIDTH-1, load `diff` from the result register and load `borrow` from the final `br'`, then go to DONE.
- **DONE**
  - `out_valid` = 1.
  - `diff` and `borrow` are stable for as long as `out_valid` is high.
  - On `out_ready`, go to IDLE.
- `in_valid` is ignored outside IDLE; `in_ready` = 0 in RUN and DONE.
- Operands are captured only at the input handshake. Changes on `a` and `b` afterwards have no effect on the operation in progress.
- `diff` and `borrow` keep the last result after the output handshake and until the next completion.
- `out_ready` is ignored when `out_valid` = 0.

## Timing
- **Reset:**
  - `rst_n` low at a clock edge forces state = IDLE, `diff` = 0, `borrow` = 0, `out_valid` = 0, `ovf` = 0, and clears all internal registers.
  - `in_ready` is combinational: `(state == IDLE) && rst_n`. It is therefore 0 while reset is asserted.
- **Latency:**
  - Input handshake at edge T0.
  - RUN occupies edges T1..TWIDTH.
  - `out_valid` goes high immediately after edge TWIDTH, i.e. WIDTH cycles after acceptance (8 for the default width).
- **Output handshake:**
  - If `out_ready` = 1 on the first DONE cycle, `out_valid` is high for exactly one cycle.
  - `in_ready` rises in the following cycle.
  - Minimum initiation interval is WIDTH+2 cycles.
- **Backpressure:** with `out_ready` held low, DONE is held indefinitely and no new operands are accepted.
- **Reset mid-operation:** reset in RUN or DONE aborts the operation. The block returns to IDLE and no result is produced.
- **Boundaries:**
  - a == b gives `diff` = 0, `borrow` = 0.
  - a = 0, b = 2^WIDTH-1 gives `diff` = 1, `borrow` = 1.

## Configuration
- Macro: `SUB_SIGNED_OVF_EN`.
- **Defined:**
  - Port `ovf` is present.
  - At completion it loads `(a_msb ^ b_msb) & (a_msb ^ d_msb)`, taken from the latched operands and the result.
  - It is held and reset exactly like `borrow`.
- **Undefined:** the `ovf` port and its logic are absent; all other behaviour is identical.

## Test plan
- **Basic subtract:** reset, then a=8'd6, b=8'd2 with `in_valid` for 1 cycle → `out_valid` 8 cycles after the handshake, `diff` = 8'd4, `borrow` = 0.
- **Wrap-around:** a=8'd2, b=8'd4 → `diff` = 8'hFE, `borrow` = 1; a=0, b=8'hFF → `diff` = 8'h01, `borrow` = 1.
- **Backpressure:**
  - Hold `out_ready` = 0 for 5 cycles after `out_valid` rises → `diff` and `borrow` stay stable and `in_ready` stays 0.
  - Assert `in_valid` with new operands during this window → they are ignored.
- **Back-to-back:** keep `out_ready` = 1 and `in_valid` = 1 continuously → a new operand pair is accepted every 10 cycles and each result matches a reference model over 256 random pairs.
- **Reset mid-RUN:**
  - Assert `rst_n` = 0 for 1 cycle at RUN bit 3 → all outputs read 0.
  - `in_ready` returns to 1 on the cycle after reset is released.
  - No `out_valid` appears for the aborted operation.
- **Signed overflow** (`SUB_SIGNED_OVF_EN` defined):
  - a=8'h80, b=8'h01 → `diff` = 8'h7F, `ovf` = 1.
  - a=8'h05, b=8'h03 → `ovf` = 0.
